mips_32: RTL and testbench
==========================

MIPS_32 -- requirements
Module: mips_32

Interface
REQ-001 Parameter MEM_DEPTH, default 1024: number of 32-bit words in unified instruction/data memory `Mem`; power of two.
REQ-002 clk1  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 halted  output  1  mirrors internal HALT flag.
REQ-005 Internal state SHALL be hierarchically accessible under these exact names:
- Reg[0:31] (32-bit register file)
- Mem[0:MEM_DEPTH-1] (32-bit words)
- pc (word address)
- HALT, TAKEN_BRANCH (1-bit flags)

Function
REQ-006 The design SHALL be a 5-stage pipeline (IF, ID, EX, MEM, WB) issuing at most one instruction per cycle.
REQ-007 Instruction fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to 32 bits.
REQ-008 R-type ops (rd <- rs op rt): ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed, result 1/0), MUL 000101 (low 32 bits).
REQ-009 I-type ops:
- ADDI 001010, SUBI 001011, SLTI 001100: rt <- rs op imm
- LW 001000: rt <- Mem[rs+imm]
- SW 001001: Mem[rs+imm] <- rt
- BNEQZ 001101, BEQZ 001110
- HLT 111111
REQ-010 Any other opcode SHALL execute as a NOP (no register, memory or pc side effect).
REQ-011 Arithmetic SHALL wrap modulo 2^32; memory and fetch addresses SHALL use the low log2(MEM_DEPTH) bits (wrap-around).
REQ-012 pc SHALL be word-addressed and increment by 1 per fetch; branch target = pc_of_branch + 1 + imm.
REQ-013 Branches SHALL test rs against zero and resolve in EX. When taken:
- set TAKEN_BRANCH for one cycle
- load pc with the target
- flush the IF and ID instructions (2-cycle penalty)
REQ-014 Reg[0] SHALL always read 0; writes to it SHALL be discarded.
REQ-015 Full forwarding from EX/MEM and MEM/WB into EX SHALL be provided.
REQ-016 A WB write and an ID read of the same register in the same cycle SHALL return the new value.
REQ-017 A load followed immediately by a dependent instruction SHALL stall IF/ID one cycle and insert a bubble into EX.
REQ-018 When HLT is decoded in ID, fetch SHALL stop.
REQ-019 When HLT reaches WB, HALT SHALL be set to 1.
REQ-020 While HALT=1, no register write, memory write or pc change SHALL occur.
REQ-021 A HLT in the shadow of a taken branch SHALL be flushed and have no effect.
REQ-022 With no stalls, the first instruction after reset release SHALL write back at the end of the 5th rising edge.

Reset
REQ-023 While rst=1, the following SHALL be forced asynchronously, including when rst is asserted mid-execution:
- pc=0, HALT=0, TAKEN_BRANCH=0
- all pipeline stages empty (NOP)
REQ-024 Reset SHALL NOT alter Reg or Mem contents, so they can be preloaded before reset release.

Configuration
REQ-025 Macro MIPS32_MUL_EN:
- defined: MUL (000101) SHALL execute per REQ-008.
- undefined: no multiplier SHALL be built and MUL SHALL execute as a NOP.

Verification
REQ-026 Reg[k]=k; Mem[0..6]=28000000,28010005,28020005,28030019,00222000,00A10822,FC000000; release rst -> after 30 cycles:
- R0=0, R1=10, R2=5, R3=25, R4=10, R5=5
- HALT=1, halted=1
REQ-027 Mem[20]=7; program LW R1,20(R0); ADD R2,R1,R1; HLT -> one stall cycle inserted; R2=14.
REQ-028 Countdown loop: R1=3; BNEQZ at loop end decrementing via SUBI R1,R1,1; HLT -> loop body runs 3 times; R1=0; the 2 instructions after each taken branch have no effect.
REQ-029 ADDI R0,R0,9 -> Reg[0] stays 0. SW R3,0(R0) with R3=25 -> Mem[0]=25.
REQ-030 Assert rst mid-program -> pc=0, HALT=0, TAKEN_BRANCH=0 immediately without a clock edge; re-run from pc=0 gives the REQ-026 results.
REQ-031 MUL R6,R2,R3 with R2=5, R3=25:
- MIPS32_MUL_EN defined: R6=125.
- undefined: R6 unchanged.

Source files
------------

// File: rtl/mips_32.sv
// mips_32: five-stage pipelined MIPS-style core over one unified word memory.
// Define MIPS32_MUL_EN to build the MUL instruction; otherwise MUL is a NOP.
module mips_32 #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic clk1,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
`ifdef MIPS32_MUL_EN
    localparam logic [5:0] OP_MUL   = 6'b000101;
`endif
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef struct packed {
        logic        v;
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs, rt, dst;
        logic [31:0] a, b, imm, npc;
        logic        wr, lw, sw, br, hlt;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu, b;
        logic [4:0]  dst;
        logic        wr, lw, sw, hlt;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] val;
        logic [4:0]  dst;
        logic        wr, hlt;
    } mem_wb_t;

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] pc;
    logic        HALT;
    logic        TAKEN_BRANCH;
    logic        stopped;

    if_id_t  if_id;
    id_ex_t  id_ex, id_nx;
    ex_mem_t ex_mem, ex_nx;
    mem_wb_t mem_wb, wb_nx;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        use_rs, use_rt, id_hlt, stall, taken, wb_en;
    logic [31:0] fa, fb, target;

    assign op  = if_id.ir[31:26];
    assign rs  = if_id.ir[25:21];
    assign rt  = if_id.ir[20:16];
    assign rd  = if_id.ir[15:11];
    assign imm = {{16{if_id.ir[15]}}, if_id.ir[15:0]};

    assign halted = HALT;
    assign wb_en  = mem_wb.wr && (mem_wb.dst != 5'd0) && !HALT;
    assign id_hlt = if_id.v && (op == OP_HLT);

    // Decode; register reads see a same-cycle write-back.
    always_comb begin
        id_nx     = '0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        id_nx.op  = op;
        id_nx.rs  = rs;
        id_nx.rt  = rt;
        id_nx.imm = imm;
        id_nx.npc = if_id.npc;
        if (rs == 5'd0)
            id_nx.a = '0;
        else if (wb_en && mem_wb.dst == rs)
            id_nx.a = mem_wb.val;
        else
            id_nx.a = Reg[rs];
        if (rt == 5'd0)
            id_nx.b = '0;
        else if (wb_en && mem_wb.dst == rt)
            id_nx.b = mem_wb.val;
        else
            id_nx.b = Reg[rt];
        if (if_id.v) begin
            unique case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                    id_nx.wr  = 1'b1;
                    id_nx.dst = rd;
                    use_rs    = 1'b1;
                    use_rt    = 1'b1;
                end
`ifdef MIPS32_MUL_EN
                OP_MUL: begin
                    id_nx.wr  = 1'b1;
                    id_nx.dst = rd;
                    use_rs    = 1'b1;
                    use_rt    = 1'b1;
                end
`endif
                OP_ADDI, OP_SUBI, OP_SLTI: begin
                    id_nx.wr  = 1'b1;
                    id_nx.dst = rt;
                    use_rs    = 1'b1;
                end
                OP_LW: begin
                    id_nx.wr  = 1'b1;
                    id_nx.lw  = 1'b1;
                    id_nx.dst = rt;
                    use_rs    = 1'b1;
                end
                OP_SW: begin
                    id_nx.sw = 1'b1;
                    use_rs   = 1'b1;
                    use_rt   = 1'b1;
                end
                OP_BNEQZ, OP_BEQZ: begin
                    id_nx.br = 1'b1;
                    use_rs   = 1'b1;
                end
                OP_HLT: id_nx.hlt = 1'b1;
                default: ;
            endcase
        end
    end

    assign stall = id_ex.lw && (id_ex.dst != 5'd0) &&
                   ((use_rs && rs == id_ex.dst) ||
                    (use_rt && rt == id_ex.dst));

    // Execute with forwarding from EX/MEM, then MEM/WB.
    always_comb begin
        fa = id_ex.a;
        if (ex_mem.wr && !ex_mem.lw && ex_mem.dst != 5'd0 &&
            ex_mem.dst == id_ex.rs)
            fa = ex_mem.alu;
        else if (mem_wb.wr && mem_wb.dst != 5'd0 &&
                 mem_wb.dst == id_ex.rs)
            fa = mem_wb.val;
        fb = id_ex.b;
        if (ex_mem.wr && !ex_mem.lw && ex_mem.dst != 5'd0 &&
            ex_mem.dst == id_ex.rt)
            fb = ex_mem.alu;
        else if (mem_wb.wr && mem_wb.dst != 5'd0 &&
                 mem_wb.dst == id_ex.rt)
            fb = mem_wb.val;
        ex_nx     = '0;
        ex_nx.dst = id_ex.dst;
        ex_nx.wr  = id_ex.wr;
        ex_nx.lw  = id_ex.lw;
        ex_nx.sw  = id_ex.sw;
        ex_nx.hlt = id_ex.hlt;
        ex_nx.b   = fb;
        unique case (id_ex.op)
            OP_ADD:  ex_nx.alu = fa + fb;
            OP_SUB:  ex_nx.alu = fa - fb;
            OP_AND:  ex_nx.alu = fa & fb;
            OP_OR:   ex_nx.alu = fa | fb;
            OP_SLT:  ex_nx.alu = {31'd0, $signed(fa) < $signed(fb)};
`ifdef MIPS32_MUL_EN
            OP_MUL:  ex_nx.alu = fa * fb;
`endif
            OP_ADDI, OP_LW, OP_SW: ex_nx.alu = fa + id_ex.imm;
            OP_SUBI: ex_nx.alu = fa - id_ex.imm;
            OP_SLTI: ex_nx.alu = {31'd0, $signed(fa) < $signed(id_ex.imm)};
            default: ex_nx.alu = '0;
        endcase
    end

    assign taken  = id_ex.br && ((id_ex.op == OP_BEQZ) == (fa == 32'd0));
    assign target = id_ex.npc + id_ex.imm;

    always_comb begin
        wb_nx     = '0;
        wb_nx.dst = ex_mem.dst;
        wb_nx.wr  = ex_mem.wr;
        wb_nx.hlt = ex_mem.hlt;
        wb_nx.val = ex_mem.lw ? Mem[ex_mem.alu[AW-1:0]] : ex_mem.alu;
    end

    // Taken branch beats load-use stall; a decoded HLT stops fetch.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc           <= '0;
            HALT         <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            stopped      <= 1'b0;
            if_id        <= '0;
            id_ex        <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
        end else if (HALT) begin
            TAKEN_BRANCH <= 1'b0;
        end else begin
            TAKEN_BRANCH <= taken;
            if (mem_wb.hlt)
                HALT <= 1'b1;
            mem_wb <= wb_nx;
            ex_mem <= ex_nx;
            if (taken) begin
                pc    <= target;
                if_id <= '0;
                id_ex <= '0;
            end else if (stall) begin
                id_ex <= '0;
            end else begin
                id_ex <= id_nx;
                if (id_hlt)
                    stopped <= 1'b1;
                if (!stopped && !id_hlt) begin
                    if_id.v   <= 1'b1;
                    if_id.ir  <= Mem[pc[AW-1:0]];
                    if_id.npc <= pc + 32'd1;
                    pc        <= pc + 32'd1;
                end else begin
                    if_id <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (wb_en)
            Reg[mem_wb.dst] <= mem_wb.val;
    end

    always_ff @(posedge clk1) begin
        if (ex_mem.sw && !HALT)
            Mem[ex_mem.alu[AW-1:0]] <= ex_mem.b;
    end

endmodule

// File: tb/tb_mips_32.sv
// Directed bench for mips_32: program table with expected register/memory
// values, plus hand sequences for latency, load-use stall and async reset.
module tb_mips_32;
    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    logic halted;

    mips_32 #(.MEM_DEPTH(1024)) dut (
        .clk1(clk1),
        .rst(rst),
        .halted(halted)
    );

    always #5 clk1 = ~clk1;

    localparam int NP = 7;
    localparam int NW = 10;
    localparam logic [31:0] HLT = 32'hFC000000;
`ifdef MIPS32_MUL_EN
    localparam logic [31:0] MUL_EXP = 32'd125;
`else
    localparam logic [31:0] MUL_EXP = 32'd6;
`endif

    typedef struct packed {
        logic [3:0]  prog;
        logic        mem;
        logic [9:0]  idx;
        logic [31:0] exp;
    } chk_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] code [0:NP-1][0:NW-1];
    int          dadr [0:NP-1];
    logic [31:0] dval [0:NP-1];
    chk_t        tbl [$];

    function automatic logic [31:0] rt_i(input logic [5:0] op,
                                         input int s, input int t,
                                         input int d);
        logic [4:0] a, b, c;
        a = s[4:0];
        b = t[4:0];
        c = d[4:0];
        return {op, a, b, c, 11'd0};
    endfunction

    function automatic logic [31:0] it_i(input logic [5:0] op,
                                         input int s, input int t,
                                         input logic [15:0] im);
        logic [4:0] a, b;
        a = s[4:0];
        b = t[4:0];
        return {op, a, b, im};
    endfunction

    task automatic add(input int p, input logic m, input int i,
                       input logic [31:0] e);
        chk_t x;
        x.prog = p[3:0];
        x.mem  = m;
        x.idx  = i[9:0];
        x.exp  = e;
        tbl.push_back(x);
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic load(input int p);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = '0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
        for (int i = 0; i < NW; i++) dut.Mem[i] = code[p][i];
        if (dadr[p] >= 0) dut.Mem[dadr[p]] = dval[p];
    endtask

    task automatic start(input int p);
        rst = 1'b1;
        @(negedge clk1);
        load(p);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string nm, input int maxc);
        int n;
        n = 0;
        while (!halted && n < maxc) begin
            @(negedge clk1);
            n++;
        end
        check({nm, " halted"}, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        int n;
        logic found;
        logic [31:0] act;
        for (int p = 0; p < NP; p++) begin
            dadr[p] = -1;
            dval[p] = '0;
            for (int i = 0; i < NW; i++) code[p][i] = '0;
        end
        code[0][0] = 32'h28000000; code[0][1] = 32'h28010005;
        code[0][2] = 32'h28020005; code[0][3] = 32'h28030019;
        code[0][4] = 32'h00222000; code[0][5] = 32'h00A10822;
        code[0][6] = 32'hFC000000;
        code[1][0] = it_i(6'b001000, 0, 1, 16'd20);
        code[1][1] = rt_i(6'b000000, 1, 1, 2);
        code[1][2] = HLT;
        dadr[1] = 20; dval[1] = 32'd7;
        code[2][0] = it_i(6'b001010, 0, 1, 16'd3);
        code[2][1] = it_i(6'b001010, 0, 4, 16'd0);
        code[2][2] = it_i(6'b001010, 4, 4, 16'd1);
        code[2][3] = it_i(6'b001011, 1, 1, 16'd1);
        code[2][4] = it_i(6'b001101, 1, 0, 16'hFFFD);
        code[2][5] = it_i(6'b001010, 6, 6, 16'd100);
        code[2][6] = HLT;
        code[3][0] = it_i(6'b001110, 0, 0, 16'd2);
        code[3][1] = HLT;
        code[3][2] = it_i(6'b001010, 0, 7, 16'd55);
        code[3][3] = it_i(6'b001010, 0, 8, 16'd77);
        code[3][4] = HLT;
        code[4][0] = it_i(6'b001010, 0, 3, 16'd25);
        code[4][1] = it_i(6'b001010, 0, 0, 16'd9);
        code[4][2] = it_i(6'b001001, 0, 3, 16'd0);
        code[4][3] = rt_i(6'b000000, 0, 0, 9);
        code[4][4] = HLT;
        code[5][0] = it_i(6'b001010, 0, 2, 16'd5);
        code[5][1] = it_i(6'b001010, 0, 3, 16'd25);
        code[5][2] = rt_i(6'b000101, 2, 3, 6);
        code[5][3] = HLT;
        code[6][0] = it_i(6'b001011, 0, 12, 16'd5);
        code[6][1] = rt_i(6'b000001, 10, 11, 13);
        code[6][2] = rt_i(6'b000010, 10, 11, 14);
        code[6][3] = rt_i(6'b000011, 10, 11, 15);
        code[6][4] = rt_i(6'b000100, 12, 10, 16);
        code[6][5] = rt_i(6'b000100, 10, 12, 17);
        code[6][6] = it_i(6'b001100, 12, 18, 16'hFFFC);
        code[6][7] = it_i(6'b001000, 0, 19, 16'hFFFF);
        code[6][8] = HLT;
        dadr[6] = 1023; dval[6] = 32'h0000DEAD;

        add(0, 0, 0, 0);  add(0, 0, 1, 10); add(0, 0, 2, 5);
        add(0, 0, 3, 25); add(0, 0, 4, 10); add(0, 0, 5, 5);
        add(1, 0, 1, 7);  add(1, 0, 2, 14);
        add(2, 0, 1, 0);  add(2, 0, 4, 3);  add(2, 0, 6, 106);
        add(3, 0, 7, 7);  add(3, 0, 8, 77);
        add(4, 0, 0, 0);  add(4, 1, 0, 25); add(4, 0, 9, 0);
        add(5, 0, 6, MUL_EXP);
        add(6, 0, 12, 32'hFFFFFFFB); add(6, 0, 13, 32'hFFFFFFFF);
        add(6, 0, 14, 10); add(6, 0, 15, 11); add(6, 0, 16, 1);
        add(6, 0, 17, 0);  add(6, 0, 18, 1);
        add(6, 0, 19, 32'h0000DEAD);

        // Reset state
        @(negedge clk1);
        check("rst pc", dut.pc, 32'd0);
        check("rst HALT", {31'd0, dut.HALT}, 32'd0);
        check("rst TB", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        check("rst halted", {31'd0, halted}, 32'd0);

        for (int p = 0; p < NP; p++) begin
            start(p);
            wait_halt($sformatf("p%0d", p), 300);
            foreach (tbl[c]) begin
                if (int'(tbl[c].prog) == p) begin
                    act = tbl[c].mem ? dut.Mem[tbl[c].idx]
                                     : dut.Reg[tbl[c].idx[4:0]];
                    check($sformatf("p%0d %s%0d", p,
                                    tbl[c].mem ? "M" : "R", tbl[c].idx),
                          act, tbl[c].exp);
                end
            end
        end

        // First write-back lands on the 5th edge
        start(6);
        repeat (4) @(posedge clk1);
        #1 check("lat edge4", dut.Reg[12], 32'd12);
        @(posedge clk1);
        #1 check("lat edge5", dut.Reg[12], 32'hFFFFFFFB);

        // Load-use stall adds one cycle before halt
        start(1);
        n = 0;
        while (n < 20) begin
            @(posedge clk1);
            #1 n++;
            if (halted) break;
        end
        check("stall edges", 32'(n), 32'd8);

        // Async reset while a branch is taken
        start(2);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk1);
            if (dut.TAKEN_BRANCH) begin
                found = 1'b1;
                break;
            end
        end
        check("tb seen", {31'd0, found}, 32'd1);
        #2 rst = 1'b1;
        #1 check("async pc", dut.pc, 32'd0);
        check("async TB", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        // Async reset after halt clears HALT but keeps Reg
        start(0);
        wait_halt("rerun0", 300);
        @(negedge clk1);
        #2 rst = 1'b1;
        #1 check("async HALT", {31'd0, dut.HALT}, 32'd0);
        check("async halted", {31'd0, halted}, 32'd0);
        check("keep R3", dut.Reg[3], 32'd25);

        // Mid-program reset, then rerun from pc 0
        @(negedge clk1);
        rst = 1'b0;
        repeat (4) @(negedge clk1);
        #2 rst = 1'b1;
        #1 check("mid pc", dut.pc, 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        wait_halt("rerun1", 300);
        check("rerun R1", dut.Reg[1], 32'd10);
        check("rerun R2", dut.Reg[2], 32'd5);
        check("rerun R3", dut.Reg[3], 32'd25);
        check("rerun R4", dut.Reg[4], 32'd10);
        check("rerun R5", dut.Reg[5], 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
